// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, state type and S-box arithmetic.
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  // Indexed by round number 1..10; unused slots are zero.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'h00
  };

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_key_schedule_ke.sv
// One AES-128 key-expansion step: next round key from the previous one.
// Purely combinational; four S-box lookups on the rotated last word.
import aes_pkg::*;

module ke (
  input  logic [KEY_W-1:0] key,
  input  logic [3:0]       rounds,
  output logic [KEY_W-1:0] next_key
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign tmp = sub ^ {RCON[rounds], 24'h0};

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key schedule: one round key per cycle into 11 registers,
// done pulses 10 cycles after start is accepted; start ignored while busy.
import aes_pkg::*;

module aes_key_schedule (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  input  logic [3:0]        rd_addr,
  output logic [KEY_W-1:0]  rd_key
);
  state_t           state;
  logic [3:0]       round_cnt;
  logic [KEY_W-1:0] working;
  logic [KEY_W-1:0] round_key;
  logic [KEY_W-1:0] rk [0:NUM_ROUNDS];

  ke u_ke (
    .key      (working),
    .rounds   (round_cnt),
    .next_key (round_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round_cnt  <= '0;
      working    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            working    <= key_in;
            rk[0]      <= key_in;
            round_cnt  <= 4'd1;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (round_cnt == 4'd0 || round_cnt > 4'(NUM_ROUNDS)) begin
            // Corrupted counter: abandon the run rather than publish garbage.
            state      <= IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            round_cnt  <= '0;
          end else begin
            for (int i = 1; i <= NUM_ROUNDS; i++)
              if (round_cnt == 4'(i)) rk[i] <= round_key;
            working <= round_key;
            if (round_cnt == 4'(NUM_ROUNDS)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              keys_valid <= 1'b1;
              done       <= 1'b1;
              round_cnt  <= '0;
            end else begin
              round_cnt <= round_cnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (rd_addr == 4'(i)) rd_key = rk[i];
  end
endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
- REQ-001 The module SHALL have no parameters; constants SHALL come from the shared package (REQ-030).
- REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003 rst  input  1  asynchronous, active-high reset.
- REQ-004 start  input  1  request to expand key_in; sampled on the rising edge of clk.
- REQ-005 key_in  input  128  cipher key, bit 127 = first key byte MSB; sampled together with start.
- REQ-006 busy  output  1  high while an expansion is in progress.
- REQ-007 done  output  1  single-cycle pulse when all 11 round keys are stored.
- REQ-008 keys_valid  output  1  high while the stored round keys form one complete schedule.
- REQ-009 rd_addr  input  4  round-key index, 0..10.
- REQ-010 rd_key  output  128  stored round key selected by rd_addr.

Function
- REQ-011 States SHALL be IDLE and RUN.
- REQ-012 IDLE plus start=1 at edge N: latch key_in into the working register and into rk[0], set round counter to 1, clear keys_valid, enter RUN, assert busy.
- REQ-013 RUN: each edge N+r (r=1..10) SHALL write rk[r] = round_step(working, r), copy the same value into working, and increment the round counter.
- REQ-014 round_step SHALL be the standard AES-128 expansion:
  - RotWord on the last word, SubWord, XOR with Rcon[r] (01,02,04,08,10,20,40,80,1B,36 in the top byte).
  - The remaining words SHALL be chained by XOR.
- REQ-015 At edge N+10 the block SHALL enter IDLE, clear busy, set keys_valid, and set done.
- REQ-016 done SHALL be cleared at edge N+11; total latency from start sample to done = 10 cycles.
- REQ-017 start SHALL be ignored while busy=1; the working register, round counter, and rk SHALL be unaffected.
- REQ-018 start in the same cycle that done is high SHALL be accepted: a new run begins, keys_valid clears, and rk[0] is overwritten.
- REQ-019 rd_key SHALL be a combinational read of rk[rd_addr] with zero latency.
- REQ-020 rd_addr 11..15 SHALL return 128'h0.
- REQ-021 rd_key SHALL be readable at any time; its contents are meaningful only when keys_valid=1.
- REQ-022 The round counter SHALL never exceed 10; an illegal counter value in RUN SHALL force IDLE with keys_valid=0.
- REQ-023 key_in changes while busy SHALL have no effect.

Reset
- REQ-024 rst=1 SHALL immediately force:
  - state IDLE, busy=0, done=0, keys_valid=0;
  - round counter 0, working register 0, all rk entries 0.
- REQ-025 rst asserted mid-RUN SHALL abort the run; no partial schedule SHALL be reported valid.
- REQ-026 After rst deassertion, the first start SHALL behave exactly as REQ-012.
- REQ-027 Reset deassertion SHALL be synchronised externally; the block adds no reset synchroniser.

Structure
- REQ-028 Exactly one round-key step SHALL be computed per cycle; a single S-box instance (4 bytes) is shared across rounds.
- REQ-029 The round step SHALL be the existing ke module, instantiated once with key=working and rounds=round counter.
- REQ-030 The shared package aes_pkg SHALL hold:
  - NUM_ROUNDS=10, KEY_W=128, the Rcon table;
  - the state enum type {IDLE, RUN}.
- REQ-031 Round-key storage SHALL be 11 x 128-bit registers, with no memory macro.

Verification
- REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done exactly 10 cycles later; then:
  - rd_addr=0 returns the key;
  - rd_addr=1 returns a0fafe1788542cb123a339392a6c7605;
  - rd_addr=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
- REQ-033 All-zero key -> rd_addr=1 returns 62636363626363636263636362636363; rd_addr=10 returns b4ef5bcb3e92e21123e951cf6f8f188e.
- REQ-034 start re-pulsed at cycles 3 and 7 of a run with a different key -> ignored; the final schedule matches the first key; exactly one done pulse.
- REQ-035 rst asserted at cycle 5 of a run -> busy, done, and keys_valid are 0 immediately and rd_key is 0 for all addresses; a new start then completes normally.
- REQ-036 Back-to-back: start held high on the done cycle with the zero key after a FIPS key run -> keys_valid drops for 10 cycles, then the zero-key schedule is reported.
- REQ-037 rd_addr=11 and rd_addr=15 while keys_valid=1 -> rd_key=0.
